// File: rtl/rca8_mul_seq_if.sv
// Start/busy/done handshake between the ALU control unit and the shift-add multiplier.
// Latency: n/a (wires only). Backpressure: start is ignored while busy is high.
// master = ALU control unit, slave = multiplier sequencer.
interface rca8_mul_seq_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        signed_mode;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (output start, a, b, signed_mode, input busy, done, product);
    modport slave  (input start, a, b, signed_mode, output busy, done, product);
endinterface

// File: rtl/rca8_mul_seq.sv
// 8x8 -> 16 shift-add multiplier sharing one RCA8 adder; optional signed mode via SIGNED_MUL_EN.
// Latency: 8 cycles accept-to-done (10 when a signed result must be negated).
// Backpressure: start is accepted only while busy is low; it is never queued.

// 8-bit ripple-carry adder.
// Latency: combinational. Backpressure: none.
// Shared by every partial-product add and the final negation.
module rca8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c_in,
    output logic [7:0] z,
    output logic       c_out
);
    logic [8:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign z[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign c_out = c[8];
endmodule

// Sequencer: IDLE -> RUN x8 -> [NEG_LO -> NEG_HI] -> DONE -> IDLE.
// Latency: 8 cycles unsigned / non-negated, 10 when the magnitude product is negated.
// Backpressure: busy high from acceptance through the done cycle; start ignored meanwhile.
module rca8_mul_seq (
    input  logic               clk,
    input  logic               rst,
    rca8_mul_seq_if.slave      bus
);
    typedef enum logic [2:0] {IDLE, RUN, NEG_LO, NEG_HI, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  m, h, l;
    logic [2:0]  cnt;
    logic [15:0] p_next;
    logic [15:0] product_q;
    logic [7:0]  add_x, add_y, add_z;
    logic        add_cin, add_cout;
    logic [7:0]  a_ld, b_ld;

`ifdef SIGNED_MUL_EN
    logic neg, neg_c;

    // Magnitudes for signed operands; 8'h80 maps to 128 naturally.
    assign a_ld = (bus.signed_mode && bus.a[7]) ? (~bus.a + 8'd1) : bus.a;
    assign b_ld = (bus.signed_mode && bus.b[7]) ? (~bus.b + 8'd1) : bus.b;
`else
    logic unused_signed_mode;

    assign unused_signed_mode = bus.signed_mode;
    assign a_ld = bus.a;
    assign b_ld = bus.b;
`endif

    rca8 u_rca8 (
        .x     (add_x),
        .y     (add_y),
        .c_in  (add_cin),
        .z     (add_z),
        .c_out (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
                if (cnt == 3'd7) begin
`ifdef SIGNED_MUL_EN
                    state_next = neg ? NEG_LO : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef SIGNED_MUL_EN
            NEG_LO:  state_next = NEG_HI;
            NEG_HI:  state_next = DONE;
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state != IDLE);
        bus.done    = (state == DONE);
        bus.product = product_q;
        add_x       = h;
        add_y       = l[0] ? m : 8'h00;
        add_cin     = 1'b0;
        p_next      = {h, l};
        case (state)
            RUN: p_next = {add_cout, add_z, l[7:1]};
`ifdef SIGNED_MUL_EN
            NEG_LO: begin
                add_x   = ~l;
                add_y   = 8'h00;
                add_cin = 1'b1;
                p_next  = {h, add_z};
            end
            NEG_HI: begin
                add_x   = ~h;
                add_y   = 8'h00;
                add_cin = neg_c;
                p_next  = {add_z, l};
            end
`endif
            default: ;
        endcase
    end

    // product only moves on the edge entering DONE, so it coincides with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m         <= 8'h00;
            h         <= 8'h00;
            l         <= 8'h00;
            cnt       <= 3'd0;
            product_q <= 16'h0000;
`ifdef SIGNED_MUL_EN
            neg       <= 1'b0;
            neg_c     <= 1'b0;
`endif
        end else begin
            if (state == IDLE) begin
                if (bus.start) begin
                    m   <= a_ld;
                    l   <= b_ld;
                    h   <= 8'h00;
                    cnt <= 3'd0;
`ifdef SIGNED_MUL_EN
                    neg <= bus.signed_mode & (bus.a[7] ^ bus.b[7]);
`endif
                end
            end else begin
                {h, l} <= p_next;
            end
            if (state == RUN) cnt <= cnt + 3'd1;
`ifdef SIGNED_MUL_EN
            if (state == NEG_LO) neg_c <= add_cout;
`endif
            if (state_next == DONE && state != DONE) product_q <= p_next;
        end
    end
endmodule

// File: tb/tb_rca8_mul_seq.sv
// Randomized + directed bench for rca8_mul_seq against an arithmetic reference model.
module tb_rca8_mul_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] last_prod = 16'h0000;

    rca8_mul_seq_if bus ();

    rca8_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic sm,
                         output logic [15:0] ep, output int el);
        ep = 16'(int'(ma) * int'(mb));
        el = 8;
`ifdef SIGNED_MUL_EN
        if (sm) begin
            ep = 16'(int'($signed(ma)) * int'($signed(mb)));
            el = (ma[7] != mb[7]) ? 10 : 8;
        end
`endif
    endtask

    // Waits for done, checking busy and product hold; returns edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 16) begin
            check("busy_run", 32'(bus.busy), 32'd1);
            check("hold", 32'(bus.product), 32'(last_prod));
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic sm);
        logic [15:0] ep;
        int el, n;
        model(ta, tb_v, sm, ep, el);
        @(negedge clk);
        bus.start = 1'b1; bus.a = ta; bus.b = tb_v; bus.signed_mode = sm;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(n);
        check("latency", 32'(n), 32'(el));
        check("product", 32'(bus.product), 32'(ep));
        check("busy_done", 32'(bus.busy), 32'd1);
        last_prod = ep;
        @(posedge clk); #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n, dones;
        bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_product", 32'(bus.product), 32'd0);
        rst = 1'b0;

        run_op(8'd10, 8'd20, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'h00, 8'hA5, 1'b0);
        run_op(8'hFD, 8'h05, 1'b1);
        run_op(8'h80, 8'h80, 1'b1);
        run_op(8'h05, 8'hFD, 1'b1);
        run_op(8'hFF, 8'h00, 1'b1);

        // start held high, operands changed during busy
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd4; bus.signed_mode = 1'b0;
        @(posedge clk); #1;
        bus.a = 8'd7; bus.b = 8'd7;
        wait_done(n);
        check("cont_latency1", 32'(n), 32'd8);
        check("cont_product1", 32'(bus.product), 32'd12);
        last_prod = 16'd12;
        @(posedge clk); #1;
        check("cont_gap", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("cont_reaccept", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(n);
        check("cont_latency2", 32'(n), 32'd8);
        check("cont_product2", 32'(bus.product), 32'd49);
        last_prod = 16'd49;
        @(posedge clk); #1;

        // reset during the 4th RUN cycle
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_product", 32'(bus.product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_prod = 16'h0000;
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op(8'd2, 8'd3, 1'b0);

        for (int i = 0; i < 40; i++)
            run_op(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rca8_mul_seq.md
# rca8_mul_seq

Multi-cycle 8x8 shift-add multiplier sequencer built around a single shared RCA8 ripple-carry adder instance. All partial-product additions go through that one RCA8, one addition per clock, so the ALU gets a 16-bit product without a combinational array multiplier. It sits beside the ALU adder path and exposes a start/busy/done handshake to the ALU control unit.

## Interface
- No parameters; widths fixed at 8-bit operands, 16-bit product.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `a`  in  8  multiplicand, sampled on the accepting edge.
- `b`  in  8  multiplier, sampled on the accepting edge.
- `signed_mode`  in  1  two's-complement request, sampled with operands; only honoured when `SIGNED_MUL_EN` is defined.
- `busy`  out  1  high from the accepting edge until return to IDLE.
- `done`  out  1  one-cycle pulse when `product` is valid.
- `product`  out  16  result register; holds until the next completion.

## Operation
- Internal registers: M[7:0] multiplicand, P[15:0] = {H,L} (L starts as the multiplier), cnt[2:0], neg.
- One RCA8 instance: X=H, Y=L[0] ? M : 0, c_in=0 during RUN.
- States:
  - IDLE: `start`=1 latches M=a, L=b, H=0, cnt=0, neg=0, then goes to RUN.
  - RUN, each cycle: P <= {c_out, Z, L[7:1]}, cnt++.
    - After the 8th iteration (cnt=7) go to NEG_LO if neg=1, else DONE.
  - NEG_LO, `SIGNED_MUL_EN` only:
    - RCA8 X=~P[7:0], Y=0, c_in=1.
    - P[7:0] <= Z; the carry is registered; go to NEG_HI.
  - NEG_HI:
    - RCA8 X=~P[15:8], Y=0, c_in=registered carry.
    - P[15:8] <= Z; go to DONE.
  - DONE: `product` <= P, `done`=1 for this cycle; next state IDLE.
- `start` while `busy`=1 is ignored; it is not queued.
- Arithmetic is modulo 2^16. An unsigned result always fits.

## Timing
- Reset, asynchronous: state=IDLE; `busy`=0, `done`=0, `product`=16'h0000; all internal registers 0.
- Accepting edge E0. RUN iterations on E1..E8. DONE state entered at E8.
  - `done`=1 and new `product` visible between E8 and E9. Unsigned latency = 8 cycles.
- Signed with neg=1: NEG_LO at E9, NEG_HI at E10. `done`/`product` visible between E10 and E11. Latency = 10.
- `busy`=1 from E0 until the edge leaving DONE, i.e. through the `done` cycle inclusive.
- A new `start` is accepted on the first edge in IDLE, earliest one cycle after `done`.
- Reset asserted mid-operation: immediate abort to reset values. No `done` is issued and the old `product` is cleared.
- `done` and `product` update coincide; `product` never changes without `done`.

## Configuration
- `SIGNED_MUL_EN` defined, on the accepting edge with `signed_mode`=1:
  - M=|a| and L=|b|, using a combinational 8-bit two's-complement negation when the sign bit is set. 8'h80 maps to unsigned 128.
  - neg = a[7]^b[7]. neg=1 triggers the NEG_LO/NEG_HI states, which reuse the RCA8.
- `SIGNED_MUL_EN` defined, `signed_mode`=0: unsigned operation.
- `SIGNED_MUL_EN` not defined:
  - `signed_mode` is ignored and all operation is unsigned.
  - NEG states and the neg register are not synthesised. Latency is always 8.

## Test plan
- Reset, then `a`=10, `b`=20, `start` pulse -> `busy` for 9 cycles; `done` exactly 8 cycles after acceptance; `product`=16'h00C8 (200).
- `a`=8'hFF, `b`=8'hFF unsigned -> `product`=16'hFE01. Then `a`=0, `b`=8'hA5 -> `product`=16'h0000 and `done` still after 8 cycles.
- `start` held high continuously with `a`=3, `b`=4, operands changed to 7/7 during `busy` -> first `product`=12. Next acceptance occurs the cycle after `done`, then `product`=49.
- `rst` pulsed on the 4th RUN cycle of 200x100 -> `busy`=0, `product`=0, no `done`. A following 2x3 gives 6.
- With `SIGNED_MUL_EN`, `signed_mode`=1:
  - `a`=8'hFD (-3), `b`=5 -> `done` at 10 cycles, `product`=16'hFFF1.
  - `a`=8'h80, `b`=8'h80 -> `done` at 8 cycles, `product`=16'h4000.
- Without `SIGNED_MUL_EN`, `signed_mode`=1, `a`=8'hFD, `b`=5 -> `product`=16'h04F1 (1265), latency 8.
